// File: rtl/noc_pkg.sv
// noc_pkg: shared NoC router definitions.
//   PORT_NUM / PORT_W : number of router ports and width of a port index
//   port_e            : port index encoding (W=0, E=1, S=2, N=3, L=4)
//   onehot_ok()       : true when a turn vector has exactly one bit set
//   onehot_idx()      : index of the set bit of a turn vector (lowest set bit)
package noc_pkg;

  localparam int PORT_NUM = 5;
  localparam int PORT_W   = 3;

  typedef enum logic [PORT_W-1:0] {
    W = 3'd0,
    E = 3'd1,
    S = 3'd2,
    N = 3'd3,
    L = 3'd4
  } port_e;

  function automatic logic onehot_ok(input logic [PORT_NUM-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < PORT_NUM; i++) n += int'(v[i]);
    return n == 1;
  endfunction

  // Only meaningful when onehot_ok(v); always returns a legal index so the
  // mux that consumes it never selects outside the port range.
  function automatic logic [PORT_W-1:0] onehot_idx(input logic [PORT_NUM-1:0] v);
    logic [PORT_W-1:0] idx;
    idx = '0;
    for (int i = PORT_NUM - 1; i >= 0; i--) begin
      if (v[i]) idx = PORT_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/noc_out_port_if.sv
// noc_out_port_if: handshake bundle between the arbiter/input FIFOs, one
// output port and its downstream link.
//   turn_i      : one-hot turn vector from the arbiter
//   in_valid_i  : input FIFO head valid, one bit per port
//   in_data_i   : input head payloads, port k at [k*DATA_W +: DATA_W]
//   in_dest_i   : input head destination index, port k at [k*PORT_W +: PORT_W]
//   in_pop_o    : pop strobe back to the input FIFOs
//   out_valid_o / out_ready_i / out_data_o : output link handshake
// Modports: slave = the output port, master = whatever drives it.
interface noc_out_port_if #(
  parameter int DATA_W = 32
);
  import noc_pkg::*;

  logic [PORT_NUM-1:0]        turn_i;
  logic [PORT_NUM-1:0]        in_valid_i;
  logic [PORT_NUM*DATA_W-1:0] in_data_i;
  logic [PORT_NUM*PORT_W-1:0] in_dest_i;
  logic [PORT_NUM-1:0]        in_pop_o;
  logic                       out_valid_o;
  logic                       out_ready_i;
  logic [DATA_W-1:0]          out_data_o;

  modport master (
    output turn_i, in_valid_i, in_data_i, in_dest_i, out_ready_i,
    input  in_pop_o, out_valid_o, out_data_o
  );

  modport slave (
    input  turn_i, in_valid_i, in_data_i, in_dest_i, out_ready_i,
    output in_pop_o, out_valid_o, out_data_o
  );

endinterface

// File: rtl/noc_out_fifo.sv
// noc_out_fifo: DEPTH x DATA_W first-word-fall-through buffer.
//   clk, rst : clock and asynchronous active-low reset
//   push/din : write din at the tail (caller guarantees !full or pop)
//   pop      : advance the head (caller guarantees !empty)
//   dout     : head entry, forced to 0 while empty
//   full/empty : occupancy flags
module noc_out_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr_reg;
  logic [AW-1:0]     rd_ptr_reg;
  logic [AW:0]       count_reg;

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage is not reset: entries are only visible through count_reg.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= din;
  end

  assign empty = (count_reg == '0);
  assign full  = (count_reg == (AW+1)'(DEPTH));
  assign dout  = empty ? '0 : mem[rd_ptr_reg];

endmodule

// File: rtl/noc_out_port.sv
// noc_out_port: one router output. Uses the arbiter's one-hot turn to pick an
// input FIFO head, pops it when it targets this port and there is room,
// buffers it and drives the output link with valid/ready.
//   clk, rst   : clock and asynchronous active-low reset
//   bus        : noc_out_port_if.slave (turn, input heads, pops, output link)
//   flit_cnt_o : flits delivered on the output link (wrapping)
//   err_o      : sticky flag, set by any cycle whose turn is not one-hot
module noc_out_port
  import noc_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int PORT_ID = 0,
  parameter int DEPTH   = 2,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  noc_out_port_if.slave     bus,
  output logic [CNT_W-1:0]  flit_cnt_o,
  output logic              err_o
);

  logic [DATA_W-1:0] head_data [PORT_NUM];
  logic [PORT_W-1:0] head_dest [PORT_NUM];

  genvar gi;
  generate
    for (gi = 0; gi < PORT_NUM; gi++) begin : g_unpack
      assign head_data[gi] = bus.in_data_i[gi*DATA_W +: DATA_W];
      assign head_dest[gi] = bus.in_dest_i[gi*PORT_W +: PORT_W];
    end
  endgenerate

  logic              turn_ok;
  logic [PORT_W-1:0] sel;
  logic              fifo_full;
  logic              fifo_empty;
  logic              xfer;
  logic              accept;
  logic [CNT_W-1:0]  flit_cnt_reg;
  logic              err_reg;

  assign turn_ok = onehot_ok(bus.turn_i);
  assign sel     = onehot_idx(bus.turn_i);

  assign bus.out_valid_o = ~fifo_empty;
  assign xfer            = bus.out_valid_o & bus.out_ready_i;

  // A full buffer still accepts when its head leaves in the same cycle.
  // Gating with rst keeps the pop strobes quiet while reset is held.
  assign accept = rst & turn_ok & bus.in_valid_i[sel]
                & (head_dest[sel] == PORT_W'(PORT_ID))
                & (~fifo_full | xfer);

  // Turn is one-hot whenever accept is high, so it doubles as the pop mask.
  assign bus.in_pop_o = accept ? bus.turn_i : '0;

  noc_out_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .din   (head_data[sel]),
    .pop   (xfer),
    .dout  (bus.out_data_o),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flit_cnt_reg <= '0;
      err_reg      <= 1'b0;
    end else begin
      if (xfer) flit_cnt_reg <= flit_cnt_reg + CNT_W'(1);
      if (!turn_ok) err_reg <= 1'b1;
    end
  end

  assign flit_cnt_o = flit_cnt_reg;
  assign err_o      = err_reg;

endmodule
